// File: rtl/pal_cfg_pkg.sv
// rtl/pal_cfg_pkg.sv - shared state type and bitstream sizing for the PAL configuration loader
package pal_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    PULSE  = 2'd2,
    FINISH = 2'd3
  } pal_cfg_state_t;

  // Two AND-plane bits per input per product term, plus one OR-plane bit per product per output
  function automatic int pal_bitstream_len(input int n, input int m, input int p);
    return 2 * n * p + p * m;
  endfunction

endpackage

// File: rtl/pal_cfg_tick_gen.sv
// rtl/pal_cfg_tick_gen.sv - half-period down-counter that paces PAL_CLK phases
module pal_cfg_tick_gen #(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  localparam int HP_W = $clog2(HALF_PERIOD + 1);

  logic [HP_W-1:0] cnt;

  // Reload on each state entry so every phase lasts exactly HALF_PERIOD cycles; park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= HP_W'(HALF_PERIOD - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - HP_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/pal_cfg_loader.sv
// rtl/pal_cfg_loader.sv - serial LSB-first bitstream loader for the PAL; optional PAL_CFG_LOCK_EN makes it one-time per reset
module pal_cfg_loader
  import pal_cfg_pkg::*;
#(
  parameter int N             = 4,
  parameter int M             = 1,
  parameter int P             = 3,
  parameter int HALF_PERIOD   = 1,
  localparam int BITSTREAM_LEN = pal_bitstream_len(N, M, P)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BITSTREAM_LEN-1:0] bitstream,
  output logic                     busy,
  output logic                     done,
  output logic                     configured,
  output logic                     pal_clk,
  output logic                     pal_cfg
);

  localparam int CNT_W = $clog2(BITSTREAM_LEN);

  pal_cfg_state_t           state;
  pal_cfg_state_t           next_state;
  logic [BITSTREAM_LEN-1:0] shreg;
  logic [CNT_W-1:0]         bit_cnt;
  logic                     tick;
  logic                     accept;
  logic                     last_bit;
  logic                     busy_d;
  logic                     done_d;
  logic                     pal_clk_d;

`ifdef PAL_CFG_LOCK_EN
  assign accept = start && !configured;
`else
  assign accept = start;
`endif

  assign last_bit = (bit_cnt == CNT_W'(BITSTREAM_LEN - 1));

  pal_cfg_tick_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .reload(next_state != state),
    .tick  (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: alternate SETUP/PULSE per bit, one FINISH cycle after the last bit
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   if (tick) next_state = PULSE;
      PULSE:   if (tick) next_state = last_bit ? FINISH : SETUP;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with state entry
  always_comb begin
    busy_d    = (next_state == SETUP) || (next_state == PULSE);
    done_d    = (next_state == FINISH);
    pal_clk_d = (next_state == PULSE);
  end

  // Output registers keep START/BITSTREAM off any combinational output path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      pal_clk <= 1'b0;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      pal_clk <= pal_clk_d;
    end
  end

  // Datapath: capture image on accept, shift at the end of each high phase, set CONFIGURED after FINISH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      pal_cfg    <= 1'b0;
      configured <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg      <= bitstream;
            bit_cnt    <= '0;
            pal_cfg    <= bitstream[0];
            configured <= 1'b0;
          end
        end
        PULSE: begin
          if (tick && !last_bit) begin
            shreg   <= {1'b0, shreg[BITSTREAM_LEN-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            pal_cfg <= shreg[1];
          end
        end
        FINISH: begin
          configured <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
